mask_share_gen: RTL and testbench

MASK_SHARE_GEN -- requirements
Module: mask_share_gen

---
 rtl/mask_share_gen.sv | 122 ++++++++++++
 tb/tb_mask_share_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_share_gen.sv
// Boolean share generator for a first-order masked half adder: splits plain A/B into
// LFSR-masked shares plus one fresh random bit. Define MASK_REFRESH_EN to step the LFSR on idle RUN cycles too.
module mask_share_gen #(
  parameter int WARMUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        i_A,
  input  logic        i_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        o_A0,
  output logic        o_A1,
  output logic        o_B0,
  output logic        o_B1,
  output logic        o_r0,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_lfsr
);

  // Handshake: a pair transfers on a clock edge where in_valid && in_ready; shares
  // transfer where out_valid && out_ready. Neither valid may depend on its ready.

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [7:0]  WARM_LAST    = 8'(WARMUP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  warm_cnt_q, warm_cnt_d;
  logic        accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    in_ready   = 1'b0;
    accept     = 1'b0;
    if (!rst) begin
      if (seed_load) begin
        // A zero seed would lock the LFSR, so substitute the default.
        lfsr_d     = (seed == 16'h0000) ? DEFAULT_SEED : seed;
        warm_cnt_d = 8'd0;
        state_d    = ST_WARMUP;
      end else begin
        case (state_q)
          ST_WARMUP: begin
            lfsr_d     = lfsr_step(lfsr_q);
            warm_cnt_d = warm_cnt_q + 8'd1;
            if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
          end
          ST_RUN: begin
            in_ready = !out_valid || out_ready;
            accept   = in_valid && in_ready;
            if (accept) begin
              // Three bits consumed, three steps taken: no mask bit is reused.
              lfsr_d = lfsr_step(lfsr_step(lfsr_step(lfsr_q)));
            end else begin
`ifdef MASK_REFRESH_EN
              lfsr_d = lfsr_step(lfsr_q);
`else
              lfsr_d = lfsr_q;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_UNSEEDED;
      lfsr_q     <= DEFAULT_SEED;
      warm_cnt_q <= 8'd0;
      out_valid  <= 1'b0;
      o_A0       <= 1'b0;
      o_A1       <= 1'b0;
      o_B0       <= 1'b0;
      o_B1       <= 1'b0;
      o_r0       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      if (accept) begin
        out_valid <= 1'b1;
        o_A0      <= i_A ^ lfsr_q[0];
        o_A1      <= lfsr_q[0];
        o_B0      <= i_B ^ lfsr_q[1];
        o_B1      <= lfsr_q[1];
        o_r0      <= lfsr_q[2];
      end else if (seed_load || out_ready) begin
        // Shares are forced to zero whenever nothing valid is held.
        out_valid <= 1'b0;
        o_A0      <= 1'b0;
        o_A1      <= 1'b0;
        o_B0      <= 1'b0;
        o_B1      <= 1'b0;
        o_r0      <= 1'b0;
      end
    end
  end

  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;

endmodule

// File: tb/tb_mask_share_gen.sv
// Directed bench for mask_share_gen: reset, seeding/warm-up, share correctness,
// back-pressure, seed_load priority, mid-transaction reset and random traffic.
module tb_mask_share_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic        i_A, i_B;
  logic        out_valid;
  logic        out_ready;
  logic        o_A0, o_A1, o_B0, o_B1, o_r0;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_lfsr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic        ov_m;
  logic [4:0]  exp_sh;

`ifdef MASK_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  mask_share_gen #(.WARMUP_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .i_A(i_A), .i_B(i_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .o_A0(o_A0), .o_A1(o_A1), .o_B0(o_B0), .o_B1(o_B1), .o_r0(o_r0),
    .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] shares_of(input logic a, input logic b, input logic [15:0] s);
    return {a ^ s[0], s[0], b ^ s[1], s[1], s[2]};
  endfunction

  task automatic idle_model();
    if (REFRESH) m_lfsr = ref_step(m_lfsr);
  endtask

  // Count in_ready-low cycles after a seed load, bounded; the LFSR steps on each.
  task automatic run_warmup(input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      cnt++;
      tick();
      m_lfsr = ref_step(m_lfsr);
    end
    check_eq({tag, "_warm_len"}, cnt, 16);
    check_eq({tag, "_run_state"}, dbg_state, 2);
    check_eq({tag, "_warm_lfsr"}, dbg_lfsr, m_lfsr);
  endtask

  // Present one pair with out_ready high and check the shares a cycle later.
  task automatic send_pair(input string tag, input logic a, input logic b);
    in_valid = 1'b1; i_A = a; i_B = b; out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, in_ready, 1);
    exp_sh = shares_of(a, b, m_lfsr);
    tick();
    m_lfsr = ref_step(ref_step(ref_step(m_lfsr)));
    check_eq({tag, "_ov"}, out_valid, 1);
    check_eq({tag, "_sh"}, {o_A0, o_A1, o_B0, o_B1, o_r0}, exp_sh);
    check_eq({tag, "_a_xor"}, o_A0 ^ o_A1, a);
    check_eq({tag, "_b_xor"}, o_B0 ^ o_B1, b);
    check_eq({tag, "_lfsr"}, dbg_lfsr, m_lfsr);
  endtask

  initial begin
    logic [15:0] warm_end;
    logic [15:0] ref_s;
    int n_acc;
    logic acc, exp_rdy;
    logic [1:0] pair;

    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; in_valid = 1'b0;
    i_A = 1'b0; i_B = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_shares", {o_A0, o_A1, o_B0, o_B1, o_r0}, 0);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_lfsr_hold", dbg_lfsr, 16'hACE1);

    // Zero seed substitutes 0xACE1
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    check_eq("zs_state", dbg_state, 1);
    check_eq("zs_lfsr", dbg_lfsr, 16'hACE1);
    check_eq("zs_first_step", ref_step(16'hACE1), 16'h59C3);
    m_lfsr = 16'hACE1;
    run_warmup("zs");

    // Four pairs back to back
    for (int k = 0; k < 4; k++) begin
      pair = 2'(k);
      send_pair($sformatf("pair%0d", k), pair[1], pair[0]);
    end
    in_valid = 1'b0;
    tick();
    idle_model();
    check_eq("drain_ov", out_valid, 0);
    check_eq("drain_sh", {o_A0, o_A1, o_B0, o_B1, o_r0}, 0);
    check_eq("drain_lfsr", dbg_lfsr, m_lfsr);

    // Back-pressure: first pair accepted, then held for 4 cycles
    in_valid = 1'b1; i_A = 1'b1; i_B = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("bp_rdy0", in_ready, 1);
    exp_sh = shares_of(1'b1, 1'b0, m_lfsr);
    tick();
    m_lfsr = ref_step(ref_step(ref_step(m_lfsr)));
    i_A = 1'b0; i_B = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_hold_rdy", in_ready, 0);
      check_eq("bp_hold_ov", out_valid, 1);
      check_eq("bp_hold_sh", {o_A0, o_A1, o_B0, o_B1, o_r0}, exp_sh);
      tick();
      idle_model();
    end
    check_eq("bp_hold_lfsr", dbg_lfsr, m_lfsr);
    send_pair("bp_next", 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    idle_model();

    // seed_load beats a simultaneous accept while output is pending
    in_valid = 1'b1; i_A = 1'b1; i_B = 1'b1; out_ready = 1'b0;
    tick();
    m_lfsr = ref_step(ref_step(ref_step(m_lfsr)));
    check_eq("sl_pending_ov", out_valid, 1);
    seed_load = 1'b1; seed = 16'h1234;
    #1;
    check_eq("sl_rdy_forced", in_ready, 0);
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    check_eq("sl_ov", out_valid, 0);
    check_eq("sl_sh", {o_A0, o_A1, o_B0, o_B1, o_r0}, 0);
    check_eq("sl_state", dbg_state, 1);
    check_eq("sl_lfsr", dbg_lfsr, 16'h1234);
    m_lfsr = 16'h1234;
    run_warmup("sl");

    // Reset in RUN with a pending output
    in_valid = 1'b1; i_A = 1'b0; i_B = 1'b1; out_ready = 1'b0;
    tick();
    check_eq("rr_pending_ov", out_valid, 1);
    rst = 1'b1; seed_load = 1'b1; seed = 16'h5555;
    #1;
    check_eq("rr_rdy_in_rst", in_ready, 0);
    tick();
    rst = 1'b0; seed_load = 1'b0; in_valid = 1'b0;
    check_eq("rr_state", dbg_state, 0);
    check_eq("rr_ov", out_valid, 0);
    check_eq("rr_sh", {o_A0, o_A1, o_B0, o_B1, o_r0}, 0);
    check_eq("rr_lfsr", dbg_lfsr, 16'hACE1);
    tick();
    check_eq("rr_unseeded_hold", dbg_lfsr, 16'hACE1);

    seed_load = 1'b1; seed = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    m_lfsr = 16'hBEEF;
    run_warmup("rnd");
    warm_end = m_lfsr;

    // Random traffic against the model
    ov_m = 1'b0; exp_sh = 5'd0; n_acc = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      i_A       = 1'($urandom_range(0, 1));
      i_B       = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !ov_m || out_ready;
      check_eq("rnd_rdy", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      tick();
      if (acc) begin
        exp_sh = shares_of(i_A, i_B, m_lfsr);
        m_lfsr = ref_step(ref_step(ref_step(m_lfsr)));
        ov_m = 1'b1;
        n_acc++;
      end else begin
        idle_model();
        if (out_ready) begin
          ov_m = 1'b0;
          exp_sh = 5'd0;
        end
      end
      check_eq("rnd_ov", out_valid, ov_m);
      check_eq("rnd_sh", {o_A0, o_A1, o_B0, o_B1, o_r0}, exp_sh);
    end
    in_valid = 1'b0;

    ref_s = warm_end;
    for (int k = 0; k < 3 * n_acc + (REFRESH ? (200 - n_acc) : 0); k++)
      ref_s = ref_step(ref_s);
    check_eq("rnd_step_count", dbg_lfsr, ref_s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
